// File: rtl/hs_split_pkg.sv
// Shared definitions for the handshake request splitter.
//   OP_LOAD / OP_STORE  : opcodes served by the default two-channel table
//   split_state_e       : splitter FSM state encoding
//   CH_OPCODE_DEFAULT   : default channel table, entry [i] belongs to channel i
package hs_split_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        HOLD,
        RTZ,
        ERR
    } split_state_e;

    // Packed index 0 is the rightmost element, so channel 0 answers OP_LOAD.
    localparam logic [1:0][6:0] CH_OPCODE_DEFAULT = {OP_STORE, OP_LOAD};

endpackage

// File: rtl/hs_split_decode.sv
// Opcode to channel-mask decoder (purely combinational).
//   opcode : opcode to classify
//   mask   : bit i set when opcode equals CH_OPCODE[i]; several bits may be set
//            when the table holds duplicate entries, none when unknown
module hs_split_decode
    import hs_split_pkg::*;
#(
    parameter int                          N_CH      = 2,
    parameter int                          OP_W      = 7,
    parameter logic [N_CH-1:0][OP_W-1:0]   CH_OPCODE = CH_OPCODE_DEFAULT
) (
    input  logic [OP_W-1:0] opcode,
    output logic [N_CH-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            mask[i] = (opcode == CH_OPCODE[i]);
        end
    end

endmodule

// File: rtl/hs_split_n.sv
// N-channel four-phase request splitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_in     : upstream request level
//   opcode     : request opcode, sampled only when a transaction starts
//   ack_in     : per-channel downstream acknowledge
//   req_out    : per-channel downstream request
//   ack_out    : merged upstream acknowledge (AND over selected channels)
//   err_out    : qualifies ack_out; unknown opcode or acknowledge timeout
//   sel_out    : channel mask latched for the current transaction
//   busy       : high whenever the splitter is not idle
//
// state | meaning
// IDLE  | waiting for req_in, decodes opcode on the accepting edge
// FWD   | req_out driven on selected channels, waiting for all their acks
// HOLD  | ack_out given upstream, waiting for req_in to drop
// RTZ   | req_out cleared, waiting for selected acks and req_in to be low
// ERR   | unknown opcode answered with ack+err, waiting for req_in to drop
module hs_split_n
    import hs_split_pkg::*;
#(
    parameter int                          N_CH      = 2,
    parameter int                          OP_W      = 7,
    parameter logic [N_CH-1:0][OP_W-1:0]   CH_OPCODE = CH_OPCODE_DEFAULT,
    parameter int                          TO_W      = 8,
    parameter int                          TO_MAX    = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_in,
    input  logic [OP_W-1:0] opcode,
    input  logic [N_CH-1:0] ack_in,
    output logic [N_CH-1:0] req_out,
    output logic            ack_out,
    output logic            err_out,
    output logic [N_CH-1:0] sel_out,
    output logic            busy
);

    split_state_e    state_q, state_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] req_q, req_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic [N_CH-1:0] dec_mask;
    logic            timeout;

    hs_split_decode #(
        .N_CH      (N_CH),
        .OP_W      (OP_W),
        .CH_OPCODE (CH_OPCODE)
    ) u_decode (
        .opcode (opcode),
        .mask   (dec_mask)
    );

    // Down-counter reloaded outside FWD; reaching zero while in FWD means the
    // edge about to be taken is the TO_MAX-th edge since FWD was entered.
    if (TO_W > 0) begin : g_timer
        localparam logic [TO_W-1:0] TMR_INIT = TO_W'(TO_MAX - 1);
        logic [TO_W-1:0] tmr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tmr_q <= '0;
            end else if (state_q != FWD) begin
                tmr_q <= TMR_INIT;
            end else if (tmr_q != '0) begin
                tmr_q <= tmr_q - 1'b1;
            end
        end

        assign timeout = (state_q == FWD) && (tmr_q == '0);
    end else begin : g_no_timer
        assign timeout = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        req_d   = req_q;
        ack_d   = ack_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_in) begin
                    mask_d = dec_mask;
                    if (dec_mask != '0) begin
                        state_d = FWD;
                        req_d   = dec_mask;
                    end else begin
                        state_d = ERR;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            FWD: begin
                // A complete ack on the same edge as expiry wins over the timeout.
                if ((ack_in & mask_q) == mask_q) begin
                    state_d = HOLD;
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d = RTZ;
                    req_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            HOLD: begin
                if (!req_in) begin
                    state_d = RTZ;
                    req_d   = '0;
                end
            end
            RTZ: begin
                // Covers both paths: after a timeout req_in may still be high.
                if (((ack_in & mask_q) == '0) && !req_in) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ERR: begin
                if (!req_in) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
                ack_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign req_out = req_q;
    assign ack_out = ack_q;
    assign err_out = err_q;
    assign sel_out = mask_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hs_split_n.sv
// Bench for hs_split_n: a default two-channel instance with a short timeout
// exercised by directed and random transactions, plus a three-channel
// multicast instance with the timeout disabled.
module tb_hs_split_n;

    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam int         TMAX = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req0;
    logic [6:0] op0;
    logic [1:0] ack0, rq0, sel0;
    logic       acko0, err0, busy0;

    logic       req1;
    logic [6:0] op1;
    logic [2:0] ack1, rq1, sel1;
    logic       acko1, err1, busy1;

    int checks = 0;
    int errors = 0;

    hs_split_n #(
        .N_CH   (2),
        .OP_W   (7),
        .TO_W   (8),
        .TO_MAX (TMAX)
    ) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req0),
        .opcode  (op0),
        .ack_in  (ack0),
        .req_out (rq0),
        .ack_out (acko0),
        .err_out (err0),
        .sel_out (sel0),
        .busy    (busy0)
    );

    hs_split_n #(
        .N_CH      (3),
        .OP_W      (7),
        .CH_OPCODE ({ST, LD, LD}),
        .TO_W      (0),
        .TO_MAX    (1)
    ) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req1),
        .opcode  (op1),
        .ack_in  (ack1),
        .req_out (rq1),
        .ack_out (acko1),
        .err_out (err1),
        .sel_out (sel1),
        .busy    (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // err is only meaningful while ack is expected high, sel only while busy.
    task automatic chk0(input string tag, input logic [1:0] r, input logic a,
                        input logic e, input logic [1:0] s, input logic b);
        chk({tag, ".req_out"}, 32'(rq0), 32'(r));
        chk({tag, ".ack_out"}, 32'(acko0), 32'(a));
        if (a) chk({tag, ".err_out"}, 32'(err0), 32'(e));
        if (b) chk({tag, ".sel_out"}, 32'(sel0), 32'(s));
        chk({tag, ".busy"}, 32'(busy0), 32'(b));
    endtask

    task automatic chk1(input string tag, input logic [2:0] r, input logic a,
                        input logic e, input logic [2:0] s, input logic b);
        chk({tag, ".req_out"}, 32'(rq1), 32'(r));
        chk({tag, ".ack_out"}, 32'(acko1), 32'(a));
        if (a) chk({tag, ".err_out"}, 32'(err1), 32'(e));
        if (b) chk({tag, ".sel_out"}, 32'(sel1), 32'(s));
        chk({tag, ".busy"}, 32'(busy1), 32'(b));
    endtask

    // Reference channel table for the default instance.
    function automatic logic [1:0] model_mask0(input logic [6:0] op);
        logic [6:0] tbl [2];
        logic [1:0] m;
        tbl[0] = LD;
        tbl[1] = ST;
        m = '0;
        for (int i = 0; i < 2; i++) m[i] = (op == tbl[i]);
        return m;
    endfunction

    // One complete transaction on dut0.  d: edge (counted from FWD entry) on
    // which all selected acks are first sampled high; d > TMAX means the acks
    // never come and the timeout must fire on edge TMAX.
    task automatic trans0(input string tag, input logic [6:0] op, input int d,
                          input int hold, input int rel, input logic [1:0] stray);
        logic [1:0] m;
        logic       to;
        int         last;
        m    = model_mask0(op);
        req0 = 1'b1;
        op0  = op;
        ack0 = stray & ~m;
        step();
        if (m == 2'b00) begin
            chk0({tag, ".err_enter"}, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1);
            for (int h = 0; h < hold; h++) begin
                op0  = 7'($urandom);
                ack0 = 2'($urandom);
                step();
                chk0({tag, ".err_hold"}, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1);
            end
            req0 = 1'b0;
            ack0 = 2'b00;
            step();
            chk0({tag, ".err_release"}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
            return;
        end
        chk0({tag, ".fwd_enter"}, m, 1'b0, 1'b0, m, 1'b1);
        to   = (d > TMAX);
        last = to ? TMAX : d;
        for (int j = 1; j <= last; j++) begin
            op0  = 7'($urandom);
            ack0 = ((!to && j >= d) ? m : 2'b00) | (stray & ~m);
            step();
            if (!to && j == d)
                chk0({tag, ".acked"}, m, 1'b1, 1'b0, m, 1'b1);
            else if (to && j == TMAX)
                chk0({tag, ".timeout"}, 2'b00, 1'b1, 1'b1, m, 1'b1);
            else
                chk0({tag, ".fwd_wait"}, m, 1'b0, 1'b0, m, 1'b1);
        end
        for (int h = 0; h < hold; h++) begin
            op0 = 7'($urandom);
            step();
            chk0({tag, ".hold"}, to ? 2'b00 : m, 1'b1, to, m, 1'b1);
        end
        req0 = 1'b0;
        step();
        if (to) begin
            chk0({tag, ".to_release"}, 2'b00, 1'b0, 1'b0, m, 1'b0);
            return;
        end
        chk0({tag, ".req_drop"}, 2'b00, 1'b1, 1'b0, m, 1'b1);
        for (int r = 0; r < rel; r++) begin
            step();
            chk0({tag, ".rtz_wait"}, 2'b00, 1'b1, 1'b0, m, 1'b1);
        end
        ack0 = stray & ~m;
        step();
        chk0({tag, ".ack_drop"}, 2'b00, 1'b0, 1'b0, m, 1'b0);
    endtask

    initial begin
        logic [6:0] op;
        int         d;
        int         sel;
        req0  = 1'b0; op0 = '0; ack0 = '0;
        req1  = 1'b0; op1 = '0; ack1 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk0("reset0", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("reset0.err_out", 32'(err0), 32'd0);
        chk("reset0.sel_out", 32'(sel0), 32'd0);
        chk1("reset1", 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        step();

        // Directed two-channel cases.
        trans0("load_min", LD, 1, 0, 0, 2'b00);
        trans0("load_slow", LD, 4, 1, 2, 2'b00);
        trans0("store_stray", ST, 3, 0, 1, 2'b01);
        trans0("unknown", 7'h33, 0, 2, 0, 2'b00);
        trans0("timeout", LD, TMAX + 5, 2, 0, 2'b00);
        trans0("late_ack", ST, TMAX - 1, 0, 0, 2'b00);
        trans0("after_to", ST, 2, 0, 0, 2'b11);

        // Mid-transaction reset while in HOLD.
        req0 = 1'b1; op0 = LD; ack0 = 2'b00;
        step();
        ack0 = 2'b01;
        step();
        chk0("pre_reset", 2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk0("async_reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("async_reset.err_out", 32'(err0), 32'd0);
        chk("async_reset.sel_out", 32'(sel0), 32'd0);
        req0 = 1'b0; ack0 = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        chk0("post_reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        trans0("fresh", ST, 2, 1, 1, 2'b00);

        // Random transactions, back-to-back or with short idle gaps.
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? LD : (sel < 8) ? ST : 7'($urandom);
            d   = $urandom_range(1, 15);
            if (d == TMAX) d = TMAX - 1;
            trans0("rand", op, d, $urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                    step();
                    chk0("rand.idle", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
                end
            end
        end

        // Multicast instance: LOAD selects channels 0 and 1.
        req1 = 1'b1; op1 = LD; ack1 = 3'b000;
        step();
        chk1("mc.enter", 3'b011, 1'b0, 1'b0, 3'b011, 1'b1);
        ack1 = 3'b001;
        op1  = ST;
        for (int j = 0; j < 20; j++) begin
            step();
            chk1("mc.partial", 3'b011, 1'b0, 1'b0, 3'b011, 1'b1);
        end
        ack1 = 3'b011;
        step();
        chk1("mc.acked", 3'b011, 1'b1, 1'b0, 3'b011, 1'b1);
        req1 = 1'b0;
        step();
        chk1("mc.req_drop", 3'b000, 1'b1, 1'b0, 3'b011, 1'b1);
        ack1 = 3'b010;
        step();
        chk1("mc.one_ack_left", 3'b000, 1'b1, 1'b0, 3'b011, 1'b1);
        ack1 = 3'b000;
        step();
        chk1("mc.idle", 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);

        req1 = 1'b1; op1 = ST; ack1 = 3'b011;
        step();
        chk1("mc.store", 3'b100, 1'b0, 1'b0, 3'b100, 1'b1);
        ack1 = 3'b111;
        step();
        chk1("mc.store_ack", 3'b100, 1'b1, 1'b0, 3'b100, 1'b1);
        req1 = 1'b0; ack1 = 3'b011;
        step();
        chk1("mc.store_drop", 3'b000, 1'b1, 1'b0, 3'b100, 1'b1);
        step();
        chk1("mc.store_idle", 3'b000, 1'b0, 1'b0, 3'b100, 1'b0);

        ack1 = 3'b000;
        req1 = 1'b1; op1 = 7'h7f;
        step();
        chk1("mc.unknown", 3'b000, 1'b1, 1'b1, 3'b000, 1'b1);
        req1 = 1'b0;
        step();
        chk1("mc.unknown_rel", 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
